xblock_lsu: RTL and testbench
=============================

Name: xblock_lsu

Overview:
Per-X-block load/store unit. It sits between the X-block register file and the shared data-memory arbiter, and is driven by the same compute-unit state code. Register-file read data (available from the WAIT state onward) supplies the address and store data. For loads it returns lsu_load_data, which the register file writes into rs1 during WRITEBACK. The scheduler holds the CU in WAIT until lsu_state reports DONE.

Parameters:
DATA_WIDTH, 16, width of register and memory data words
ADDR_WIDTH, 8, memory address width; address is rs2_data[ADDR_WIDTH-1:0]
TIMEOUT_CYCLES, 255, watchdog limit; used only when XBLOCK_LSU_TIMEOUT_EN is defined

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
lsu_enable  in  1  X-block active in this CU; when low, FSM holds in IDLE
cu_state  in  4  CU state code: IDLE=0, FETCH=1, DECODE=2, REQ=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7
is_read  in  1  decoded load (LDR)
is_write  in  1  decoded store (STR)
rs1_data  in  DATA_WIDTH  store data
rs2_data  in  DATA_WIDTH  load/store address
mem_read_valid  out  1  read request
mem_read_addr  out  ADDR_WIDTH  read address
mem_read_ready  in  1  read response strobe; mem_read_data valid this cycle
mem_read_data  in  DATA_WIDTH  read response data
mem_write_valid  out  1  write request
mem_write_addr  out  ADDR_WIDTH  write address
mem_write_data  out  DATA_WIDTH  write data
mem_write_ready  in  1  write accepted
lsu_state  out  2  IDLE=0, REQUESTING=1, DONE=2, ERROR=3
lsu_load_data  out  DATA_WIDTH  last loaded word, registered
lsu_error  out  1  sticky timeout flag

Behaviour:
- All outputs are registered. Reset values are 0 for every output: lsu_state=IDLE, both valids 0, addresses 0, write data 0, lsu_load_data 0, lsu_error 0.
- IDLE -> REQUESTING:
  - Condition: lsu_enable && cu_state==WAIT && (is_read || is_write).
  - On that edge, latch address (and data for stores) and assert the matching *_valid.
  - If is_read and is_write are both set, the read wins; no write is issued.
- REQUESTING:
  - *_valid, addr and data are held constant until the matching ready is sampled high.
  - On the ready edge: deassert valid; for a read, capture mem_read_data into lsu_load_data; go to DONE.
  - Ready is ignored in IDLE, DONE and ERROR, and ready for the non-requested direction is ignored.
- Minimum latency: request visible 1 cycle after WAIT is entered. With ready returned in the first valid cycle, DONE is reached 2 cycles after WAIT entry.
- DONE -> IDLE when cu_state==WRITEBACK. lsu_load_data is retained until the next load completes, and is never cleared except by reset.
- Abort: if cu_state==IDLE while lsu_state!=IDLE, go to IDLE and drop valid on the next edge. lsu_error and lsu_load_data are unchanged. Memory must tolerate a withdrawn request.
- lsu_enable low forces IDLE with the same abort semantics.
- Non-memory instructions: the FSM stays in IDLE and never leaves it.
- Reset mid-transaction: valid deasserts on the reset edge.

Optional Feature:
XBLOCK_LSU_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entering REQUESTING and increments each REQUESTING cycle without ready.
  - When it reaches TIMEOUT_CYCLES: drop valid, set lsu_error=1 (sticky until reset), go to ERROR.
  - ERROR -> IDLE when cu_state==IDLE; lsu_load_data is unchanged.
- Not defined: no counter, lsu_error tied to 0, state ERROR unreachable, the unit waits indefinitely.

Decomposition:
- Shared package xblock_pkg holds:
  - CU state localparams (IDLE..DONE, 4-bit), which must match the register file's codes.
  - LSU state codes (2-bit).
  - Default DATA_WIDTH.
- No sub-module. The watchdog is inline, under the macro.

Test Plan:
- Load, zero-wait: rs2_data=0x0012, is_read=1, cu_state REQ->WAIT, mem_read_ready=1 with data 0xBEEF on first valid cycle -> mem_read_addr=0x12, valid high for exactly 1 cycle, lsu_state=DONE 2 cycles after WAIT, lsu_load_data=0xBEEF, back to IDLE on WRITEBACK.
- Store with 3-cycle stall: rs1_data=0x1234, rs2_data=0x00A0 -> mem_write_valid held 4 cycles with addr 0xA0 and data 0x1234 stable, then DONE; mem_read_valid never asserts.
- Priority and idle: is_read=is_write=1 -> only mem_read_valid asserts. ALU instruction through WAIT -> lsu_state stays IDLE.
- Abort/reset: cu_state forced to IDLE, then reset, during REQUESTING -> valid drops next edge, lsu_state=IDLE, lsu_load_data keeps prior 0xBEEF (abort) and becomes 0 (reset).
- Spurious ready: mem_read_ready pulsed in IDLE and DONE -> no state change, lsu_load_data unchanged.
- With XBLOCK_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: read with ready never asserted -> valid drops after 4 cycles, lsu_state=ERROR, lsu_error=1; cu_state=IDLE -> lsu_state IDLE, lsu_error stays 1.

Source files
------------

// File: rtl/xblock_pkg.sv
// Shared definitions for the X-block compute unit.
// CU state codes must stay identical to the register file's codes.
// LSU state codes are reported to the scheduler on lsu_state.
package xblock_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Compute-unit state codes
  localparam logic [3:0] CU_IDLE      = 4'd0;
  localparam logic [3:0] CU_FETCH     = 4'd1;
  localparam logic [3:0] CU_DECODE    = 4'd2;
  localparam logic [3:0] CU_REQ       = 4'd3;
  localparam logic [3:0] CU_WAIT      = 4'd4;
  localparam logic [3:0] CU_EXECUTE   = 4'd5;
  localparam logic [3:0] CU_WRITEBACK = 4'd6;
  localparam logic [3:0] CU_DONE      = 4'd7;

  // Load/store unit state codes
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_DONE       = 2'd2,
    LSU_ERROR      = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/xblock_lsu_if.sv
// Data-memory request/response bus between the LSU and the shared arbiter.
// master = LSU side (issues requests), slave = memory/arbiter side.
interface xblock_lsu_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);

  logic                  mem_read_valid;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic                  mem_read_ready;
  logic [DATA_WIDTH-1:0] mem_read_data;

  logic                  mem_write_valid;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_addr,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_addr, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_addr,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_addr, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/xblock_lsu.sv
// Per-X-block load/store unit.
// Issues one memory read or write per load/store instruction while the CU
// sits in WAIT, returns the loaded word for writeback, and aborts cleanly
// when the CU goes idle or the block is disabled.
// Optional watchdog: define XBLOCK_LSU_TIMEOUT_EN to abandon a request that
// is not answered within TIMEOUT_CYCLES cycles (sets sticky lsu_error).
module xblock_lsu
  import xblock_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_enable,
  input  logic [3:0]            cu_state,
  input  logic                  is_read,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  xblock_lsu_if.master          mem,
  output logic [1:0]            lsu_state,
  output logic [DATA_WIDTH-1:0] lsu_load_data,
  output logic                  lsu_error
);

  lsu_state_e            state_q, state_d;
  logic                  read_valid_q, read_valid_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  write_valid_q, write_valid_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  abort;

  // CU leaving the instruction or the block being disabled withdraws any request
  assign abort = !lsu_enable || (cu_state == CU_IDLE);

`ifdef XBLOCK_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic             timeout_hit;

  // Last unanswered cycle: the count would reach TIMEOUT_CYCLES on this edge
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign lsu_error   = error_q;
`else
  logic unused_timeout;

  assign lsu_error      = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

  // Only the low address bits of rs2 reach memory
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, rs2_data[DATA_WIDTH-1:ADDR_WIDTH]};

  // Next-state and next-output logic
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    read_valid_d  = read_valid_q;
    read_addr_d   = read_addr_q;
    write_valid_d = write_valid_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    load_data_d   = load_data_q;
`ifdef XBLOCK_LSU_TIMEOUT_EN
    cnt_d         = cnt_q;
    error_d       = error_q;
`endif

    case (state_q)
      LSU_IDLE: begin
        if (cu_state == CU_WAIT && (is_read || is_write)) begin
          state_d = LSU_REQUESTING;
          if (is_read) begin
            // Read wins when both are decoded
            read_valid_d = 1'b1;
            read_addr_d  = rs2_data[ADDR_WIDTH-1:0];
          end else begin
            write_valid_d = 1'b1;
            write_addr_d  = rs2_data[ADDR_WIDTH-1:0];
            write_data_d  = rs1_data;
          end
`ifdef XBLOCK_LSU_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      LSU_REQUESTING: begin
        if (read_valid_q && mem.mem_read_ready) begin
          read_valid_d = 1'b0;
          load_data_d  = mem.mem_read_data;
          state_d      = LSU_DONE;
        end else if (write_valid_q && mem.mem_write_ready) begin
          write_valid_d = 1'b0;
          state_d       = LSU_DONE;
        end
`ifdef XBLOCK_LSU_TIMEOUT_EN
        else if (timeout_hit) begin
          read_valid_d  = 1'b0;
          write_valid_d = 1'b0;
          error_d       = 1'b1;
          state_d       = LSU_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      LSU_DONE: begin
        if (cu_state == CU_WRITEBACK) state_d = LSU_IDLE;
      end
      default: begin
        // ERROR is left only through the abort path below
      end
    endcase

    if (abort) begin
      state_d       = LSU_IDLE;
      read_valid_d  = 1'b0;
      write_valid_d = 1'b0;
      load_data_d   = load_data_q;
`ifdef XBLOCK_LSU_TIMEOUT_EN
      error_d       = error_q;
`endif
    end
  end

  // State and output registers with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LSU_IDLE;
      read_valid_q  <= 1'b0;
      read_addr_q   <= '0;
      write_valid_q <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      load_data_q   <= '0;
`ifdef XBLOCK_LSU_TIMEOUT_EN
      cnt_q         <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      read_valid_q  <= read_valid_d;
      read_addr_q   <= read_addr_d;
      write_valid_q <= write_valid_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      load_data_q   <= load_data_d;
`ifdef XBLOCK_LSU_TIMEOUT_EN
      cnt_q         <= cnt_d;
      error_q       <= error_d;
`endif
    end
  end

  assign mem.mem_read_valid  = read_valid_q;
  assign mem.mem_read_addr   = read_addr_q;
  assign mem.mem_write_valid = write_valid_q;
  assign mem.mem_write_addr  = write_addr_q;
  assign mem.mem_write_data  = write_data_q;
  assign lsu_state           = state_q;
  assign lsu_load_data       = load_data_q;

endmodule

// File: tb/tb_xblock_lsu.sv
// Self-checking bench for xblock_lsu: a table of load/store/ALU instructions
// walked through the CU sequence with a request scoreboard, followed by
// hand-written abort, enable, spurious-ready, watchdog and reset sequences.
module tb_xblock_lsu;
  import xblock_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          lsu_enable;
  logic [3:0]    cu_state;
  logic          is_read;
  logic          is_write;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_load_data;
  logic          lsu_error;

  xblock_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

  xblock_lsu #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lsu_enable   (lsu_enable),
    .cu_state     (cu_state),
    .is_read      (is_read),
    .is_write     (is_write),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .mem          (mem_bus),
    .lsu_state    (lsu_state),
    .lsu_load_data(lsu_load_data),
    .lsu_error    (lsu_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rd;
    logic          wr;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    int            stall;
    logic [DW-1:0] rdata;
    logic          exp_rd;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic          is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  vec_t          vecs[$];
  req_t          sb[$];
  logic [DW-1:0] exp_load;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic rd, input logic wr,
                         input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                         input int stall, input logic [DW-1:0] rdata,
                         input logic exp_rd, input logic exp_wr,
                         input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_data);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.rs1 = rs1; v.rs2 = rs2;
    v.stall = stall; v.rdata = rdata; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    v.exp_addr = exp_addr; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  // Walk the CU through DECODE/REQ/WAIT and leave it in WAIT for one edge
  task automatic enter_wait(input logic rd, input logic wr,
                            input logic [DW-1:0] rs1, input logic [DW-1:0] rs2);
    cu_state = CU_DECODE; is_read = rd; is_write = wr; rs1_data = rs1; rs2_data = rs2;
    tick();
    cu_state = CU_REQ;
    tick();
    cu_state = CU_WAIT;
  endtask

  task automatic finish_instr();
    cu_state = CU_DONE; is_read = 1'b0; is_write = 1'b0;
    tick();
    cu_state = CU_IDLE;
    tick();
  endtask

  task automatic run_txn(input vec_t v);
    req_t e;
    req_t got;
    enter_wait(v.rd, v.wr, v.rs1, v.rs2);
    if (v.exp_rd || v.exp_wr) begin
      e.is_rd = v.exp_rd; e.addr = v.exp_addr; e.data = v.exp_data;
      sb.push_back(e);
    end
    tick();
    if (!(v.exp_rd || v.exp_wr)) begin
      check({v.name, " state_after_wait"}, lsu_state, LSU_IDLE);
      check({v.name, " no_valid"}, {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
      cu_state = CU_WRITEBACK;
      tick();
      check({v.name, " state_writeback"}, lsu_state, LSU_IDLE);
    end else begin
      check({v.name, " state_req"}, lsu_state, LSU_REQUESTING);
      check({v.name, " valids"}, {mem_bus.mem_read_valid, mem_bus.mem_write_valid},
            {v.exp_rd, v.exp_wr});
      if (sb.size() == 0) begin
        check({v.name, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        if (got.is_rd) begin
          check({v.name, " read_addr"}, mem_bus.mem_read_addr, got.addr);
        end else begin
          check({v.name, " write_addr"}, mem_bus.mem_write_addr, got.addr);
          check({v.name, " write_data"}, mem_bus.mem_write_data, got.data);
        end
      end
      for (int s = 0; s < v.stall; s++) begin
        // Ready for the other direction must be ignored
        if (v.exp_rd) mem_bus.mem_write_ready = 1'b1;
        else begin mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 16'hDEAD; end
        tick();
        mem_bus.mem_read_ready = 1'b0; mem_bus.mem_write_ready = 1'b0;
        check({v.name, " stall_state"}, lsu_state, LSU_REQUESTING);
        check({v.name, " stall_valids"}, {mem_bus.mem_read_valid, mem_bus.mem_write_valid},
              {v.exp_rd, v.exp_wr});
        if (v.exp_rd) check({v.name, " stall_raddr"}, mem_bus.mem_read_addr, v.exp_addr);
        else check({v.name, " stall_wdata"}, {mem_bus.mem_write_addr, mem_bus.mem_write_data},
                   {v.exp_addr, v.exp_data});
        check({v.name, " stall_load"}, lsu_load_data, exp_load);
      end
      if (v.exp_rd) begin
        mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = v.rdata;
      end else begin
        mem_bus.mem_write_ready = 1'b1;
      end
      tick();
      mem_bus.mem_read_ready = 1'b0; mem_bus.mem_write_ready = 1'b0;
      if (v.exp_rd) exp_load = v.rdata;
      check({v.name, " state_done"}, lsu_state, LSU_DONE);
      check({v.name, " valids_dropped"}, {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
      check({v.name, " load_data"}, lsu_load_data, exp_load);
      // Spurious ready while DONE
      cu_state = CU_EXECUTE;
      mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 16'hDEAD;
      tick();
      mem_bus.mem_read_ready = 1'b0;
      check({v.name, " done_spurious_state"}, lsu_state, LSU_DONE);
      check({v.name, " done_spurious_load"}, lsu_load_data, exp_load);
      cu_state = CU_WRITEBACK;
      tick();
      check({v.name, " state_idle_wb"}, lsu_state, LSU_IDLE);
    end
    finish_instr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; lsu_enable = 1'b0; cu_state = CU_IDLE;
    is_read = 1'b0; is_write = 1'b0; rs1_data = '0; rs2_data = '0;
    mem_bus.mem_read_ready = 1'b0; mem_bus.mem_read_data = '0;
    mem_bus.mem_write_ready = 1'b0;
    exp_load = '0;

    add_vec("ld_zero_wait", 1, 0, 16'h0000, 16'h0012, 0, 16'hBEEF, 1, 0, 8'h12, 16'h0000);
    add_vec("st_stall3",    0, 1, 16'h1234, 16'h00A0, 3, 16'h0000, 0, 1, 8'hA0, 16'h1234);
    add_vec("rd_wr_prio",   1, 1, 16'h7777, 16'h0055, 1, 16'h0F0F, 1, 0, 8'h55, 16'h0000);
    add_vec("alu_instr",    0, 0, 16'h4321, 16'h0099, 0, 16'h0000, 0, 0, 8'h00, 16'h0000);
    add_vec("ld_hi_addr",   1, 0, 16'h0000, 16'hFF33, 2, 16'hBEEF, 1, 0, 8'h33, 16'h0000);

    repeat (2) tick();
    check("rst_state", lsu_state, LSU_IDLE);
    check("rst_valids", {mem_bus.mem_read_valid, mem_bus.mem_write_valid}, 2'b00);
    check("rst_addrs", {mem_bus.mem_read_addr, mem_bus.mem_write_addr}, 16'h0000);
    check("rst_wdata", mem_bus.mem_write_data, 16'h0000);
    check("rst_load", lsu_load_data, 16'h0000);
    check("rst_error", lsu_error, 1'b0);
    reset = 1'b0; lsu_enable = 1'b1;
    tick();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Spurious ready in IDLE
    cu_state = CU_FETCH;
    mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 16'hDEAD; mem_bus.mem_write_ready = 1'b1;
    tick();
    mem_bus.mem_read_ready = 1'b0; mem_bus.mem_write_ready = 1'b0;
    check("idle_spurious_state", lsu_state, LSU_IDLE);
    check("idle_spurious_load", lsu_load_data, exp_load);

    // Abort by CU returning to IDLE
    enter_wait(1, 0, 16'h0000, 16'h0044);
    tick();
    check("abort_req_valid", mem_bus.mem_read_valid, 1'b1);
    cu_state = CU_IDLE;
    tick();
    check("abort_valid", mem_bus.mem_read_valid, 1'b0);
    check("abort_state", lsu_state, LSU_IDLE);
    check("abort_load_kept", lsu_load_data, 16'hBEEF);
    check("abort_error", lsu_error, 1'b0);

    // Abort by lsu_enable going low; WAIT alone must not restart the unit
    enter_wait(0, 1, 16'h5A5A, 16'h0066);
    tick();
    check("en_req", {mem_bus.mem_write_valid, mem_bus.mem_write_data}, {1'b1, 16'h5A5A});
    lsu_enable = 1'b0;
    tick();
    check("en_low_valid", mem_bus.mem_write_valid, 1'b0);
    check("en_low_state", lsu_state, LSU_IDLE);
    tick();
    check("en_low_hold", {lsu_state, mem_bus.mem_write_valid}, 3'b000);
    lsu_enable = 1'b1;
    finish_instr();

    // Unanswered read
    enter_wait(1, 0, 16'h0000, 16'h0077);
    tick();
    check("to_req_valid", mem_bus.mem_read_valid, 1'b1);
`ifdef XBLOCK_LSU_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_still_valid", {lsu_state, mem_bus.mem_read_valid}, {LSU_REQUESTING, 1'b1});
    end
    tick();
    check("to_valid_drop", mem_bus.mem_read_valid, 1'b0);
    check("to_state_error", lsu_state, LSU_ERROR);
    check("to_error_set", lsu_error, 1'b1);
    cu_state = CU_EXECUTE;
    tick();
    check("to_error_hold", lsu_state, LSU_ERROR);
    cu_state = CU_IDLE;
    tick();
    check("to_back_idle", lsu_state, LSU_IDLE);
    check("to_error_sticky", lsu_error, 1'b1);
    check("to_load_kept", lsu_load_data, 16'hBEEF);
`else
    repeat (20) tick();
    check("nto_waiting", {lsu_state, mem_bus.mem_read_valid}, {LSU_REQUESTING, 1'b1});
    check("nto_no_error", lsu_error, 1'b0);
    cu_state = CU_IDLE;
    tick();
    check("nto_abort_idle", lsu_state, LSU_IDLE);
`endif
    finish_instr();

    // Reset in the middle of a read
    enter_wait(1, 0, 16'h0000, 16'h0011);
    tick();
    check("rst_mid_req", mem_bus.mem_read_valid, 1'b1);
    reset = 1'b1;
    tick();
    exp_load = '0;
    check("rst_mid_valid", mem_bus.mem_read_valid, 1'b0);
    check("rst_mid_state", lsu_state, LSU_IDLE);
    check("rst_mid_load", lsu_load_data, exp_load);
    check("rst_mid_error", lsu_error, 1'b0);
    check("rst_mid_addr", mem_bus.mem_read_addr, 8'h00);
    reset = 1'b0;
    finish_instr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
